// File: rtl/scalar_vec_scaler.sv
// scalar_vec_scaler: y = a*b (mode 0) or y = c + a*b (mode 1), where a is a
// signed fixed-point scalar and b, c are packed signed vectors. The vector is
// processed LANES elements per clock. Results are saturated to WIDTH bits, and
// a sticky flag records whether any element saturated.
module scalar_vec_scaler #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int SIZE_B = 16,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic signed [WIDTH-1:0]  a,
  input  logic [WIDTH*SIZE_B-1:0]  b,
  input  logic [WIDTH*SIZE_B-1:0]  c,
  output logic [WIDTH*SIZE_B-1:0]  y,
  output logic                     busy,
  output logic                     done,
  output logic                     sat
);

  localparam int GROUPS = SIZE_B / LANES;
  localparam int KW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH*SIZE_B-1:0]  b_q, b_d;
  logic [WIDTH*SIZE_B-1:0]  c_q, c_d;
  logic                     mode_q, mode_d;
  logic [WIDTH*SIZE_B-1:0]  y_q, y_d;
  logic                     sat_q, sat_d;

  logic [WIDTH*LANES-1:0]   lane_y;
  logic [LANES-1:0]         lane_sat;

  // Full-precision product, then an arithmetic shift that drops the fraction
  // (rounds toward minus infinity). The result is widened by one guard bit so
  // that the later addend cannot wrap.
  function automatic logic signed [2*WIDTH:0] mul_shift(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] s
  );
    logic signed [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(x) * (2*WIDTH)'(s);
    return (2*WIDTH+1)'(p >>> FRAC);
  endfunction

  // Clamp to the WIDTH-bit signed range. The top bit of the result is the
  // flag that reports whether clamping occurred.
  function automatic logic [WIDTH:0] saturate(input logic signed [2*WIDTH:0] v);
    if (v[2*WIDTH:WIDTH-1] == {(WIDTH+2){v[2*WIDTH]}})
      return {1'b0, v[WIDTH-1:0]};
    else if (v[2*WIDTH])
      return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // One element: scaled product, optional addend, saturation.
  function automatic logic [WIDTH:0] elem(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] be,
    input logic signed [WIDTH-1:0] ce,
    input logic                    md
  );
    logic signed [2*WIDTH:0] sum;
    sum = mul_shift(x, be);
    if (md) sum = sum + (2*WIDTH+1)'(ce);
    return saturate(sum);
  endfunction

  // Datapath for the current group k: LANES elements in parallel.
  always_comb begin
    lane_y   = '0;
    lane_sat = '0;
    for (int l = 0; l < LANES; l++) begin
      {lane_sat[l], lane_y[WIDTH*l +: WIDTH]} =
        elem(a_q,
             b_q[WIDTH*(int'(k_q)*LANES + l) +: WIDTH],
             c_q[WIDTH*(int'(k_q)*LANES + l) +: WIDTH],
             mode_q);
    end
  end

  // FSM next-state: operands are accepted only in IDLE, groups are written in
  // RUN, and DONE lasts one cycle and ignores start.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mode_d  = mode_q;
    y_d     = y_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          mode_d  = mode;
          k_d     = '0;
          sat_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        y_d[WIDTH*LANES*int'(k_q) +: WIDTH*LANES] = lane_y;
        sat_d = sat_q | (|lane_sat);
        if (k_q == K_LAST) state_d = DONE;
        else               k_d     = k_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mode_q  <= 1'b0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign y    = y_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sat  = sat_q;

endmodule

// File: tb/tb_scalar_vec_scaler.sv
// Directed testbench for scalar_vec_scaler at default parameters
// (WIDTH=32, FRAC=16, SIZE_B=16, LANES=4).
module tb_scalar_vec_scaler;

  localparam int W = 32;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           mode;
  logic [W-1:0]   a;
  logic [W*N-1:0] b;
  logic [W*N-1:0] c;
  logic [W*N-1:0] y;
  logic           busy;
  logic           done;
  logic           sat;

  int total = 0;
  int bad   = 0;
  int n;
  logic seen_done;

  scalar_vec_scaler dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .c     (c),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] yel(input int i);
    return y[W*i +: W];
  endfunction

  // Present start for one edge (the "edge 0" of an operation).
  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      cnt++;
      if (done) break;
    end
  endtask

  // The edge after done must return to idle.
  task automatic finish_op(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"},     {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    a = '0; b = '0; c = '0;
    #12;
    chk("rst_y0",   yel(0),  32'd0);
    chk("rst_y15",  yel(15), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sat",  {31'd0, sat},  32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // mode 0, a = 1.0, b[i] = i
    a = 32'h0001_0000; mode = 1'b0;
    for (int i = 0; i < N; i++) b[W*i +: W] = i * 32'h0001_0000;
    launch();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("t1_lat", n, 32'd4);
    for (int i = 0; i < N; i++) chk($sformatf("t1_y%0d", i), yel(i), i * 32'h0001_0000);
    chk("t1_sat", {31'd0, sat}, 32'd0);
    finish_op("t1");

    // mode 1, a = -0.5, c[i] = 1.0: y[i] = 1.0 - i*0.5
    a = 32'hFFFF_8000; mode = 1'b1;
    for (int i = 0; i < N; i++) c[W*i +: W] = 32'h0001_0000;
    launch();
    wait_done(n);
    chk("t2_lat", n, 32'd4);
    for (int i = 0; i < N; i++)
      chk($sformatf("t2_y%0d", i), yel(i), 32'h0001_0000 - i * 32'h0000_8000);
    chk("t2_y15_abs", yel(15), 32'hFFF9_8000);
    chk("t2_sat", {31'd0, sat}, 32'd0);
    finish_op("t2");

    // saturation at both rails, mode 0
    a = 32'h7FFF_0000; mode = 1'b0; b = '0; c = '0;
    b[W*15 +: W] = 32'h000F_0000;
    b[W*0  +: W] = 32'hFFF1_0000;
    launch();
    wait_done(n);
    chk("t3_y15", yel(15), 32'h7FFF_FFFF);
    chk("t3_y0",  yel(0),  32'h8000_0000);
    chk("t3_y5",  yel(5),  32'd0);
    chk("t3_sat", {31'd0, sat}, 32'd1);
    finish_op("t3");
    chk("t3_sat_hold", {31'd0, sat}, 32'd1);

    // mode 1 addend overflow needs guard bits
    a = 32'h0001_0000; mode = 1'b1; b = '0; c = '0;
    b[W*0 +: W] = 32'h7FFF_FFFF; c[W*0 +: W] = 32'h7FFF_FFFF;
    b[W*1 +: W] = 32'h8000_0000; c[W*1 +: W] = 32'h8000_0000;
    b[W*2 +: W] = 32'h4000_0000; c[W*2 +: W] = 32'hC000_0000;
    launch();
    wait_done(n);
    chk("t3b_y0", yel(0), 32'h7FFF_FFFF);
    chk("t3b_y1", yel(1), 32'h8000_0000);
    chk("t3b_y2", yel(2), 32'd0);
    chk("t3b_sat", {31'd0, sat}, 32'd1);
    finish_op("t3b");

    // floor truncation of the smallest products; sat cleared by new start
    a = 32'h0000_0001; mode = 1'b0; c = '0;
    for (int i = 0; i < N; i++) b[W*i +: W] = 32'hFFFF_FFFF;
    launch();
    chk("t4_sat_clr", {31'd0, sat}, 32'd0);
    wait_done(n);
    chk("t4_y0",  yel(0),  32'hFFFF_FFFF);
    chk("t4_y9",  yel(9),  32'hFFFF_FFFF);
    chk("t4_y15", yel(15), 32'hFFFF_FFFF);
    finish_op("t4");
    for (int i = 0; i < N; i++) b[W*i +: W] = 32'h0000_0001;
    launch();
    wait_done(n);
    chk("t4b_y0",  yel(0),  32'd0);
    chk("t4b_y15", yel(15), 32'd0);
    finish_op("t4b");

    // start re-asserted mid-run with a different a is ignored
    a = 32'h0001_0000; mode = 1'b0;
    for (int i = 0; i < N; i++) b[W*i +: W] = i * 32'h0001_0000;
    launch();
    @(posedge clk); #1;
    start = 1'b1; a = 32'h0002_0000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("t5_lat", n, 32'd2);
    chk("t5_y3",  yel(3),  32'h0003_0000);
    chk("t5_y15", yel(15), 32'h000F_0000);
    finish_op("t5");

    // reset mid-run aborts without a done pulse
    a = 32'h0001_0000;
    launch();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6_y3",   yel(3), 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_sat",  {31'd0, sat},  32'd0);
    @(negedge clk); reset = 1'b0;
    seen_done = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("t6_no_done", {31'd0, seen_done}, 32'd0);

    // back-to-back: start during done ignored, next cycle accepted
    a = 32'h0001_0000;
    launch();
    wait_done(n);
    chk("t7_lat1", n, 32'd4);
    start = 1'b1; a = 32'h0002_0000;
    @(posedge clk); #1;
    chk("t7_ign_busy", {31'd0, busy}, 32'd0);
    chk("t7_ign_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("t7_acc_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("t7_lat2", n, 32'd4);
    for (int i = 0; i < N; i += 5) chk($sformatf("t7_y%0d", i), yel(i), i * 32'h0002_0000);
    finish_op("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
